// File: rtl/microtile_out_logger.sv
// Clocked capture stage for a combinational Wokwi microtile output bus: glitch-filters uo_out and
// logs each qualified change as a {timestamp, value} record into a first-word-fall-through FIFO.
module microtile_out_logger #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TS_W   = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DATA_W-1:0]           tile_out,
  output logic                        rec_valid,
  input  logic                        rec_ready,
  output logic [TS_W+DATA_W-1:0]      rec_data,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow,
  input  logic                        clr_ovf
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;
  localparam int unsigned CntW   = $clog2(SETTLE + 1);
  localparam int unsigned RecW   = TS_W + DATA_W;

  localparam logic [CntW-1:0]   SettleMax  = CntW'(SETTLE);
  localparam logic [CntW-1:0]   SettleLast = CntW'(SETTLE - 1);
  localparam logic [CountW-1:0] FullCount  = CountW'(DEPTH);

  logic [DATA_W-1:0] s0_q, cand_q, cand_d, last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q;
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [RecW-1:0]   hold_q;
  logic [RecW-1:0]   mem_q [DEPTH];

  logic push, pop, full, wr_en, drop;

  assign push  = en && (s0_q == cand_q) && (cnt_q == SettleLast) && (cand_q != last_q);
  assign full  = (count_q == FullCount);
  assign pop   = rec_valid && rec_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  assign rec_valid = (count_q != '0);
  assign rec_data  = rec_valid ? mem_q[rptr_q] : hold_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (s0_q != cand_q) begin
      cand_d = s0_q;
      cnt_d  = '0;
    end else if (!en) begin
      cnt_d = '0;
    end else if (cnt_q < SettleMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    last_d     = push ? cand_q : last_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en && !pop) begin
      count_d = count_q + CountW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CountW'(1);
    end
    if (clr_ovf) overflow_d = 1'b0;
    if (drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q       <= '0;
      cand_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      ts_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      s0_q       <= tile_out;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      ts_q       <= ts_q + TS_W'(1);
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hold_q     <= rec_data;
      if (wr_en) wptr_q <= wptr_q + PtrW'(1);
      if (pop)   rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: an empty FIFO shows hold_q, never an unwritten slot.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= {ts_q, cand_q};
  end

endmodule

// File: tb/tb_microtile_out_logger.sv
// Randomized and directed bench for microtile_out_logger against a sample-history/queue model.
module tb_microtile_out_logger;

  localparam int DATA_W = 8;
  localparam int TS_W   = 8;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   en = 1'b1;
  logic [DATA_W-1:0]      tile_out = '0;
  logic                   rec_valid;
  logic                   rec_ready = 1'b0;
  logic [TS_W+DATA_W-1:0] rec_data;
  logic [2:0]             count;
  logic                   overflow;
  logic                   clr_ovf = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  microtile_out_logger #(
    .DATA_W(DATA_W),
    .TS_W  (TS_W),
    .DEPTH (DEPTH),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .tile_out (tile_out),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_data (rec_data),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: s0 is the previous tile sample, cand the one before; a value qualifies when it has
  // been seen on SETTLE+1 consecutive samples with enable high throughout.
  logic [DATA_W-1:0]      m_s0, m_cand, m_last;
  int                     m_streak;
  int                     m_ts;
  logic [TS_W+DATA_W-1:0] m_q[$];
  logic [TS_W+DATA_W-1:0] m_hold;
  logic                   m_ovf;
  logic                   m_eq, m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s0 = '0; m_cand = '0; m_last = '0; m_streak = 0; m_ts = 0;
      m_q.delete(); m_hold = '0; m_ovf = 1'b0;
    end else begin
      m_eq   = (m_s0 == m_cand);
      m_push = en && m_eq && (m_streak == SETTLE - 1) && (m_s0 != m_last);
      m_pop  = rec_ready && (m_q.size() != 0);
      if (m_q.size() != 0) m_hold = m_q[0];
      if (m_pop) void'(m_q.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (m_push) begin
        m_last = m_s0;
        if (m_q.size() < DEPTH) m_q.push_back({m_ts[TS_W-1:0], m_s0});
        else m_ovf = 1'b1;
      end
      m_streak = (en && m_eq) ? m_streak + 1 : 0;
      m_cand   = m_s0;
      m_s0     = tile_out;
      m_ts     = (m_ts + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rec_valid", rec_valid, m_q.size() != 0);
      check("count", count, m_q.size());
      check("overflow", overflow, m_ovf);
      check("rec_data", rec_data, (m_q.size() != 0) ? m_q[0] : m_hold);
    end
  end

  task automatic do_reset();
    rst = 1'b1; tile_out = '0; en = 1'b1; rec_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold_val(input logic [7:0] v, input int n);
    tile_out = v;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // All-zero output after reset is never logged.
    do_reset();
    repeat (20) @(negedge clk);
    check("zero_count", count, 0);
    check("zero_valid", rec_valid, 0);
    check("zero_ovf", overflow, 0);

    // First-record latency and timestamp.
    do_reset();
    repeat (9) @(negedge clk);
    tile_out = 8'h5A;
    repeat (3) @(negedge clk);
    check("lat_not_yet", rec_valid, 0);
    @(negedge clk);
    check("lat_valid", rec_valid, 1);
    check("lat_data", rec_data, {8'd12, 8'h5A});
    check("lat_count", count, 1);

    // Short glitch and return to last value are not logged; a held change is.
    hold_val(8'hFF, 2);
    hold_val(8'h5A, 5);
    check("glitch_count", count, 1);
    hold_val(8'hFF, 4);
    check("ff_count", count, 2);
    rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    rec_ready = 1'b0;
    check("drained", count, 0);

    // Overflow: five values into four slots.
    for (int v = 1; v <= 5; v++) hold_val(v[7:0], 4);
    check("ovf_count", count, 4);
    check("ovf_set", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_order", rec_data[7:0], i);
      rec_ready = 1'b1;
      @(negedge clk);
      rec_ready = 1'b0;
    end
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_clear", overflow, 0);

    // Full FIFO with a pop in the push cycle accepts the record.
    for (int v = 8'h11; v <= 8'h14; v++) hold_val(v[7:0], 4);
    check("full_count", count, 4);
    hold_val(8'h15, 3);
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    check("fullpop_count", count, 4);
    check("fullpop_ovf", overflow, 0);
    check("fullpop_head", rec_data[7:0], 8'h12);

    // Asynchronous reset with entries queued.
    rec_ready = 1'b1;
    @(negedge clk);
    rec_ready = 1'b0;
    check("pre_rst_count", count, 3);
    #2 rst = 1'b1;
    #1;
    check("rst_valid", rec_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rec_data, 0);
    @(negedge clk);
    tile_out = 8'h77;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_data", rec_data, {8'd3, 8'h77});

    // Timestamp wraps past 255.
    do_reset();
    repeat (253) @(negedge clk);
    hold_val(8'h3C, 4);
    check("wrap_data", rec_data, {8'h00, 8'h3C});
    check("wrap_count", count, 1);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: tile_out = 8'h00;
          1: tile_out = 8'hA5;
          2: tile_out = 8'h3C;
          3: tile_out = 8'hC3;
          default: tile_out = 8'($urandom);
        endcase
      end
      en        = ($urandom_range(0, 9) != 0);
      rec_ready = ($urandom_range(0, 2) == 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
